// File: rtl/icache_readback.sv
// Sweeps a window of the instruction SRAM through its test port and streams each word
// out on a valid/ready interface while accumulating a wrapping checksum.
module icache_readback #(
  parameter int D_WIDTH  = 32,
  parameter int SA_WIDTH = 10,
  parameter int RD_LAT   = 1
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                Start,
  input  logic [SA_WIDTH-1:0] Base,
  input  logic [SA_WIDTH:0]   Count,
  output logic [SA_WIDTH-1:0] Mem_Addr,
  output logic                Mem_En,
  output logic                Mem_RW,
  input  logic [D_WIDTH-1:0]  Mem_Data_I,
  output logic                Out_Valid,
  input  logic                Out_Ready,
  output logic [D_WIDTH-1:0]  Out_Data,
  output logic [SA_WIDTH-1:0] Out_Addr,
  output logic                Busy,
  output logic                Done,
  output logic [D_WIDTH-1:0]  Checksum
);

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0] LAT_LAST = CW'(RD_LAT - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DONE} state_t;

  state_t              state, state_n;
  logic [SA_WIDTH-1:0] base;
  logic [SA_WIDTH:0]   count, idx, idx_inc;
  logic [CW-1:0]       lat_cnt;
  logic                accept, start_ok;

  assign idx_inc  = idx + 1'b1;
  assign Mem_Addr = base + idx[SA_WIDTH-1:0];
  assign Mem_En   = (state == S_REQ);
  assign Mem_RW   = 1'b0;
  assign Out_Valid = (state == S_HOLD);
  assign Busy     = (state == S_REQ) || (state == S_WAIT) || (state == S_HOLD);
  assign Done     = (state == S_DONE);
  assign accept   = Out_Valid && Out_Ready;
  assign start_ok = Start && ((state == S_IDLE) || (state == S_DONE));

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_DONE: if (Start) state_n = (Count == '0) ? S_DONE : S_REQ;
      S_REQ:          state_n = S_WAIT;
      S_WAIT:         if (lat_cnt == LAT_LAST) state_n = S_HOLD;
      S_HOLD:         if (Out_Ready) state_n = (idx_inc == count) ? S_DONE : S_REQ;
      default:        state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= S_IDLE;
      base     <= '0;
      count    <= '0;
      idx      <= '0;
      lat_cnt  <= '0;
      Out_Data <= '0;
      Out_Addr <= '0;
      Checksum <= '0;
    end else begin
      state <= state_n;
      if (start_ok) begin
        base     <= Base;
        count    <= Count;
        idx      <= '0;
        Checksum <= '0;
      end
      // Address is latched at issue so it stays paired with the returning data.
      if (state == S_REQ) begin
        Out_Addr <= Mem_Addr;
        lat_cnt  <= '0;
      end
      if (state == S_WAIT) begin
        if (lat_cnt == LAT_LAST) begin
          Out_Data <= Mem_Data_I;
          lat_cnt  <= '0;
        end else begin
          lat_cnt <= lat_cnt + 1'b1;
        end
      end
      if (accept) begin
        Checksum <= Checksum + Out_Data;
        idx      <= idx_inc;
      end
    end
  end

endmodule
